// File: rtl/ntt_stage_controller.sv
// ntt_stage_controller: sequences the stages of an NTT over a bank of butterfly cores.
// For each stage it walks the BRAM read addresses 0..WORDS-1, then waits PIPE_LAT
// cycles so the last butterfly result is written before the next stage reads.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   start               - begin a full transform (sampled in IDLE only)
//   busy, done          - high in RUN/DRAIN; one-cycle completion pulse
//   log_m, i, mode      - stage index, group index, twiddle addressing mode
//   read_adress         - BRAM read address (0 outside RUN)
//   write_enable        - BRAM write strobe, PIPE_LAT cycles after the matching read
//   upper/lower_write_address - delayed read address (0 when not writing)
module ntt_stage_controller #(
  parameter int unsigned STAGES         = 12,
  parameter int unsigned WORDS          = 512,
  parameter int unsigned PIPE_LAT       = 4,
  parameter int unsigned LOG_CORE_COUNT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] log_m,
  output logic [9:0] i,
  output logic [8:0] read_adress,
  output logic [1:0] mode,
  output logic       write_enable,
  output logic [8:0] upper_write_address,
  output logic [8:0] lower_write_address
);

  localparam int unsigned AW = 9;
  localparam int unsigned LW = 4;
  localparam int unsigned CW = 4;

  localparam logic [AW-1:0] LAST_RA    = AW'(WORDS - 1);
  localparam logic [LW-1:0] LAST_STAGE = LW'(STAGES - 1);
  localparam logic [LW-1:0] CORE_LOG   = LW'(LOG_CORE_COUNT);
  localparam logic [CW-1:0] LAST_CNT   = CW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] log_m_q, log_m_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [PIPE_LAT-1:0] vld_q;
  logic [AW-1:0]       adr_q [PIPE_LAT];

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      log_m_q <= '0;
      ra_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      log_m_q <= log_m_d;
      ra_q    <= ra_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; read address and drain count fall back to 0 unless advanced
  always_comb begin
    state_d = state_q;
    log_m_d = log_m_q;
    ra_d    = '0;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          log_m_d = '0;
        end
      end
      S_RUN: begin
        if (ra_q == LAST_RA) begin
          state_d = S_DRAIN;
        end else begin
          ra_d = ra_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == LAST_CNT) begin
          if (log_m_q == LAST_STAGE) begin
            state_d = S_DONE;
          end else begin
            log_m_d = log_m_q + LW'(1);
            state_d = S_RUN;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Write-side delay line: valid marks addresses issued during RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < int'(PIPE_LAT); k++) begin
        adr_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= (state_q == S_RUN);
      adr_q[0] <= ra_q;
      for (int k = 1; k < int'(PIPE_LAT); k++) begin
        vld_q[k] <= vld_q[k-1];
        adr_q[k] <= adr_q[k-1];
      end
    end
  end

  // Twiddle mode and group index, decoded from the current stage and read address
  always_comb begin
    mode = 2'd1;
    i    = '0;
    if (log_m_q < CORE_LOG) begin
      mode = 2'd0;
    end else if (log_m_q == LAST_STAGE) begin
      mode = 2'd2;
    end else begin
      i = {1'b0, ra_q} >> (LAST_STAGE - log_m_q);
    end
  end

  assign busy                = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done                = (state_q == S_DONE);
  assign log_m               = log_m_q;
  assign read_adress         = ra_q;
  assign write_enable        = vld_q[PIPE_LAT-1];
  assign upper_write_address = vld_q[PIPE_LAT-1] ? adr_q[PIPE_LAT-1] : '0;
  assign lower_write_address = vld_q[PIPE_LAT-1] ? adr_q[PIPE_LAT-1] : '0;

endmodule

// File: doc/ntt_stage_controller.md
NTT_STAGE_CONTROLLER -- requirements
Module: ntt_stage_controller

Interface
REQ-001 SHALL have parameter STAGES, default 12: number of NTT stages; log_m runs 0..STAGES-1.
REQ-002 SHALL have parameter WORDS, default 512: read addresses per stage, 0..WORDS-1.
REQ-003 SHALL have parameter PIPE_LAT, default 4: cycles from read_adress issue to the matching write_enable, covering twiddle-index register, BRAM read and butterfly.
REQ-004 SHALL have parameter LOG_CORE_COUNT, default 5: log2 of the core count, used for mode selection.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit: request a full transform, sampled in IDLE only.
REQ-008 SHALL have port busy, output, 1 bit: high in RUN and DRAIN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port log_m, output, 4 bits: current stage to the cores.
REQ-011 SHALL have port i, output, 10 bits: group index to the cores.
REQ-012 SHALL have port read_adress, output, 9 bits: BRAM read address to the cores.
REQ-013 SHALL have port mode, output, 2 bits: twiddle addressing mode to the cores.
REQ-014 SHALL have port write_enable, output, 1 bit: BRAM write strobe to the cores.
REQ-015 SHALL have ports upper_write_address and lower_write_address, outputs, 9 bits each: BRAM write addresses.

Function
REQ-016 SHALL implement the states IDLE, RUN, DRAIN and DONE, all registered.
REQ-017 IDLE with start=1 SHALL go to RUN next cycle with log_m=0 and read_adress=0; start=0 SHALL stay in IDLE.
REQ-018 RUN SHALL increment read_adress by 1 every cycle; at read_adress=WORDS-1 it SHALL go to DRAIN next cycle.
REQ-019 DRAIN SHALL last exactly PIPE_LAT cycles.
REQ-020 At DRAIN end, if log_m<STAGES-1, the block SHALL increment log_m and return to RUN with read_adress=0.
REQ-021 At DRAIN end, if log_m=STAGES-1, the block SHALL go to DONE.
REQ-022 DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE; log_m SHALL hold STAGES-1 until the next start.
REQ-023 Outside RUN, read_adress SHALL be 0.
REQ-024 Stage timing SHALL be WORDS+PIPE_LAT cycles per stage, with no read of stage k+1 before the last write of stage k, so there is no read-after-write hazard.
REQ-025 mode SHALL be:
- 0 when log_m<LOG_CORE_COUNT;
- 2 when log_m=STAGES-1;
- 1 otherwise.
REQ-026 i SHALL be 0 in modes 0 and 2.
REQ-027 In mode 1, i SHALL be {1'b0,read_adress} >> (STAGES-1-log_m), combinationally consistent with read_adress in the same cycle.
REQ-028 A PIPE_LAT-deep shift register SHALL carry a valid bit (1 only in RUN) plus read_adress.
REQ-029 write_enable SHALL be the shift-register output valid; upper_write_address and lower_write_address SHALL both be its delayed address.
REQ-030 A read issued at cycle t with address a SHALL produce write_enable=1 with address a at cycle t+PIPE_LAT.
REQ-031 When write_enable=0, the write addresses SHALL be 0.
REQ-032 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-033 start held high continuously SHALL begin a new transform on the IDLE cycle that follows DONE.
REQ-034 Counters SHALL be wide enough for PIPE_LAT up to 15 and WORDS up to 512, and SHALL never wrap within a stage.

Reset
REQ-035 rst=1 at a clock edge SHALL force IDLE and clear the valid shift register in any state, including mid-RUN or mid-DRAIN, so no write_enable is issued after reset.
REQ-036 After reset, the outputs SHALL be 0: busy, done, log_m, i, read_adress, mode, write_enable, upper_write_address, lower_write_address.
REQ-037 rst SHALL take priority over start in the same cycle.

Verification (defaults; start high at cycle 0)
REQ-038 Start: cycle 1 read_adress=0, busy=1, log_m=0, mode=0 -> cycle 5 write_enable=1 with both write addresses 0 -> cycle 512 read_adress=511 -> cycles 513..516 DRAIN, read_adress=0, write of address 511 at cycle 516 -> cycle 517 log_m=1, read_adress=0.
REQ-039 Full run: busy high for 12*516=6192 cycles (cycles 1..6192) -> done=1 only at cycle 6193 -> IDLE at cycle 6194.
REQ-040 Mode sweep: log_m=4 gives mode=0; log_m=5 gives mode=1; log_m=11 gives mode=2. At log_m=5 with read_adress=64, i=1; with read_adress=511, i=7.
REQ-041 Reset mid-RUN: rst at stage 3, read_adress=200 -> next cycle all outputs 0 -> no write_enable for the following 10 cycles.
REQ-042 Start during busy: pulse start at cycle 300 -> no effect on counters, and done still occurs at cycle 6193. Start held high -> second transform RUN begins at cycle 6195.
